// File: rtl/audio_out_serializer.sv
// audio_out_serializer: stereo sample FIFO feeding an I2S DAC stream.
// Define MONO_MIX_EN to send (L+R)>>>1 on both channels.
// Ports:
//   clock, reset (async, high)
//   l_audio_in, r_audio_in : sample pair
//   ready                  : write strobe
//   sclk, lrclk, sdata     : I2S stream
//   fifo_count             : pairs buffered
//   overflow, underflow    : slip pulses
module audio_out_serializer #(
    parameter int SAMPLE_WIDTH = 18,
    parameter int CLK_DIV      = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [SAMPLE_WIDTH-1:0]       l_audio_in,
    input  logic [SAMPLE_WIDTH-1:0]       r_audio_in,
    input  logic                          ready,
    output logic                          sclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int SW   = SAMPLE_WIDTH;
    localparam int CW   = $clog2(CLK_DIV);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int PAD  = 31 - SW;

    logic [CW-1:0]   div_cnt;
    logic            div_tc;
    logic            fall;
    logic [5:0]      bit_idx;
    logic [5:0]      nxt_idx;
    logic            frame_start;
    logic [63:0]     shreg;

    logic [2*SW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    logic [SW-1:0]   held_l;
    logic [SW-1:0]   held_r;
    logic [SW-1:0]   src_l;
    logic [SW-1:0]   src_r;
    logic [SW-1:0]   new_l;
    logic [SW-1:0]   new_r;
    logic [63:0]     frame_word;

    assign div_tc      = (div_cnt == CW'(CLK_DIV - 1));
    assign fall        = div_tc & sclk;
    assign nxt_idx     = bit_idx + 6'd1;
    assign frame_start = fall & (bit_idx == 6'd63);

    assign empty = (fifo_count == '0);
    assign full  = (fifo_count == CNTW'(FIFO_DEPTH));
    assign pop   = frame_start & ~empty;
    // A pop in the same cycle frees the slot a full-FIFO write needs.
    assign push  = ready & (~full | pop);
    assign drop  = ready & full & ~pop;

    // Empty at frame start: repeat the last pair sent.
    assign src_l = pop ? mem[rd_ptr][2*SW-1:SW] : held_l;
    assign src_r = pop ? mem[rd_ptr][SW-1:0]    : held_r;

`ifdef MONO_MIX_EN
    logic signed [SW:0] mix_sum;
    assign mix_sum = $signed({src_l[SW-1], src_l})
                   + $signed({src_r[SW-1], src_r});
    assign new_l = mix_sum[SW:1];
    assign new_r = mix_sum[SW:1];
`else
    assign new_l = src_l;
    assign new_r = src_r;
`endif

    // Slot 0 and slot 32 are the I2S one-bit delay.
    assign frame_word = {1'b0, new_l, {PAD{1'b0}},
                         1'b0, new_r, {PAD{1'b0}}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_idx   <= 6'd63;
            lrclk     <= 1'b1;
            sdata     <= 1'b0;
            shreg     <= '0;
            held_l    <= '0;
            held_r    <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= frame_start & empty;
            if (fall) begin
                bit_idx <= nxt_idx;
                lrclk   <= nxt_idx[5];
                if (frame_start) begin
                    sdata  <= frame_word[63];
                    shreg  <= {frame_word[62:0], 1'b0};
                    held_l <= new_l;
                    held_r <= new_r;
                end else begin
                    sdata <= shreg[63];
                    shreg <= {shreg[62:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {l_audio_in, r_audio_in};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= drop;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
        end
    end

endmodule

// File: doc/audio_out_serializer.md
Name: audio_out_serializer

Overview:
Output-side counterpart of the audio processing chain. Accepts processed stereo 18-bit samples on a `ready` strobe and buffers them in a small stereo FIFO. Serializes them to the DAC as an I2S-format stream (sclk, lrclk, sdata) generated from the system clock. Reports FIFO overflow and underflow so the mixer/debug logic can track sample slips.

Parameters:
SAMPLE_WIDTH, 18, bits per channel sample (MSB-first on the wire)
CLK_DIV, 4, system clocks per sclk half-period (≥2)
FIFO_DEPTH, 4, stereo pairs buffered (power of two)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
l_audio_in  in  SAMPLE_WIDTH  left sample, two's complement
r_audio_in  in  SAMPLE_WIDTH  right sample, two's complement
ready  in  1  write strobe; one pair written per cycle high
sclk  out  1  serial bit clock
lrclk  out  1  word select, 0 = left, 1 = right
sdata  out  1  serial data, changes on sclk falling edge
fifo_count  out  $clog2(FIFO_DEPTH)+1  stereo pairs currently buffered
overflow  out  1  one-cycle pulse: write dropped (FIFO full)
underflow  out  1  one-cycle pulse: frame started with FIFO empty

Behaviour:
- Reset (async, immediate): sclk=0, lrclk=1, sdata=0, fifo_count=0, overflow=0, underflow=0. Divider count=0, bit_idx=63, held pair={0,0}.
- Divider: counts 0..CLK_DIV-1. At terminal count it wraps and sclk toggles. sclk period = 2*CLK_DIV clocks.
- Frame: 64 sclk periods. bit_idx advances mod 64 on the clock cycle sclk goes 1→0 (falling event); lrclk, sdata and bit_idx update in that same cycle.
- lrclk = 0 for bit_idx 0..31, 1 for 32..63.
- sdata by bit_idx:
  - 1..SAMPLE_WIDTH: L[SAMPLE_WIDTH-bit_idx]
  - 33..32+SAMPLE_WIDTH: R[SAMPLE_WIDTH-(bit_idx-32)]
  - all other slots, including 0 and 32 (the I2S one-bit delay): 0
- First falling event after reset occurs 2*CLK_DIV cycles after reset release, giving bit_idx=0, lrclk=0.
- Pop: on the falling event entering bit_idx=0:
  - FIFO non-empty: pop head pair into the 64-bit frame shift register and into the held pair.
  - FIFO empty: reload the held pair (repeat last sample; zeros if none since reset) and pulse underflow for that cycle.
- Write: ready=1 and FIFO not full → push {l,r}. If full → drop the sample and pulse overflow.
- Simultaneous push and pop:
  - FIFO full: both succeed, count unchanged, no overflow.
  - FIFO empty: pop sees empty (underflow pulses), push is stored. No bypass.
- fifo_count is registered and reflects all pushes/pops of the previous cycle.
- Samples already loaded into the shift register are never altered mid-frame.
- Reset mid-frame aborts the frame immediately, and the serial outputs return to reset values.

Optional Feature:
MONO_MIX_EN: when defined, the popped pair is replaced by M=(L+R)>>>1 on both channels. The sum is computed at SAMPLE_WIDTH+1 bits, the shift is arithmetic, and the result truncates to SAMPLE_WIDTH, so there is no overflow. Without the macro, L and R pass through unchanged. FIFO and timing are identical in both cases.

Test Plan:
- Reset release, no ready, CLK_DIV=4: first sclk fall at cycle 8, lrclk 1→0. underflow pulses at that cycle; sdata all zeros for 64 bits.
- Push L=18'h2_AAAA, R=18'h1_5555 before the first frame: left slots 1..18 carry 10_1010_1010_1010_1010 and right slots 33..50 carry 01_0101_0101_0101_0101. Slots 0, 19..32 and 51..63 are 0; fifo_count returns 1→0.
- Five consecutive ready cycles with FIFO_DEPTH=4 and no pop: fifo_count=4 and overflow pulses exactly once, on the fifth write. The fifth sample is never transmitted.
- ready aligned with the pop cycle while full: fifo_count stays 4, no overflow, and the next frame carries the old head.
- Single push then three idle frames: the same pair is repeated in each, and underflow pulses at frames 2 and 3.
- MONO_MIX_EN, L=18'h1FFFF, R=18'h00001: both channels transmit 18'h10000. L=18'h20000, R=18'h20000: both transmit 18'h20000.
